// File: rtl/dmem_responder_if.sv
// Data-port bus between the CPU data port (master) and the data-memory responder (slave).
// Latency: none, this is wiring only. Backpressure: none; the master holds each request until ready pulses.
// Signals: cs/dm_w/dm_r/select/addr/data_in flow master->slave; data_out/ready/err flow slave->master.
interface dmem_responder_if;
  logic        cs;
  logic        dm_w;
  logic        dm_r;
  logic [2:0]  select;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ready;
  logic        err;

  modport master (
    output cs, dm_w, dm_r, select, addr, data_in,
    input  data_out, ready, err
  );

  modport slave (
    input  cs, dm_w, dm_r, select, addr, data_in,
    output data_out, ready, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word/half/byte access to an on-chip RAM, with wait states and error reporting.
// Latency: ready pulses WAIT_CYCLES+1 cycles after the cycle a request is accepted in IDLE.
// Backpressure: requests are sampled only in IDLE; the master holds its request until the single-cycle ready pulse.
// Ports: clk, reset (async, active-low), bus (dmem_responder_if.slave),
//        rd_count/wr_count (successful read/write counters, only when DMEM_ACCESS_COUNT_EN is defined).
// Parameters: DEPTH (32-bit words, at least 2), WAIT_CYCLES (0..15).
module dmem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  dmem_responder_if.slave    bus
`ifdef DMEM_ACCESS_COUNT_EN
  ,
  output logic [31:0]        rd_count,
  output logic [31:0]        wr_count
`endif
);

  localparam int          IW    = $clog2(DEPTH);
  localparam logic [31:0] LIMIT = 32'(4 * DEPTH);
  localparam logic [3:0]  LAST  = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        accept;
  logic        go_resp;

  // Request captured at accept; used for the remainder of the transaction.
  logic        lat_w, lat_r;
  logic [2:0]  lat_sel;
  logic [31:0] lat_addr, lat_din;

  logic        ready_q, err_q;
  logic [31:0] data_q;

  logic [31:0] mem [DEPTH];

  logic req;
  assign req = bus.cs & (bus.dm_r | bus.dm_w);

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    go_resp   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nxt = ST_RESP;
            go_resp   = 1'b1;
          end else begin
            state_nxt = ST_WAIT;
            cnt_nxt   = 4'd0;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == LAST) begin
          state_nxt = ST_RESP;
          go_resp   = 1'b1;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- access decode
  // With WAIT_CYCLES=0 the RAM is touched on the accept edge itself, before the
  // latches hold anything, so the live bus is used while still in IDLE.
  logic        cur_w, cur_r;
  logic [2:0]  cur_sel;
  logic [31:0] cur_addr, cur_din;

  always_comb begin
    cur_w    = lat_w;
    cur_r    = lat_r;
    cur_sel  = lat_sel;
    cur_addr = lat_addr;
    cur_din  = lat_din;
    if (state == ST_IDLE) begin
      cur_w    = bus.dm_w;
      cur_r    = bus.dm_r;
      cur_sel  = bus.select;
      cur_addr = bus.addr;
      cur_din  = bus.data_in;
    end
  end

  logic is_word, is_half, is_byte, bad;
  assign is_word = (cur_sel == 3'd0);
  assign is_half = (cur_sel == 3'd1) || (cur_sel == 3'd2);
  assign is_byte = (cur_sel == 3'd3) || (cur_sel == 3'd4);

  // Full 32-bit range check: high addresses are rejected, never aliased.
  assign bad = (cur_w & cur_r)
             | (cur_sel > 3'd4)
             | (cur_addr >= LIMIT)
             | (is_word & (cur_addr[1:0] != 2'b00))
             | (is_half & cur_addr[0]);

  logic [IW-1:0] idx;
  logic [31:0]   rd_word;
  assign idx     = cur_addr[IW+1:2];
  assign rd_word = mem[idx];

  // Read path: pick lane, move to bit 0, extend.
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] rd_ext;

  always_comb begin
    case (cur_addr[1:0])
      2'd0:    lane_b = rd_word[7:0];
      2'd1:    lane_b = rd_word[15:8];
      2'd2:    lane_b = rd_word[23:16];
      default: lane_b = rd_word[31:24];
    endcase
    lane_h = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (cur_sel)
      3'd1:    rd_ext = {16'h0000, lane_h};
      3'd2:    rd_ext = {{16{lane_h[15]}}, lane_h};
      3'd3:    rd_ext = {24'h000000, lane_b};
      3'd4:    rd_ext = {{24{lane_b[7]}}, lane_b};
      default: rd_ext = rd_word;
    endcase
  end

  // Write path: replicate the write data across lanes, merge under a lane mask.
  logic [31:0] wr_mask, wr_data, wr_word;

  always_comb begin
    wr_mask = 32'hFFFF_FFFF;
    wr_data = cur_din;
    if (is_half) begin
      wr_data = {2{cur_din[15:0]}};
      wr_mask = cur_addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
    end else if (is_byte) begin
      wr_data = {4{cur_din[7:0]}};
      wr_mask = 32'h0000_00FF << {cur_addr[1:0], 3'b000};
    end
    wr_word = (rd_word & ~wr_mask) | (wr_data & wr_mask);
  end

  logic mem_we, rd_upd;
  assign mem_we = go_resp & ~bad & cur_w;
  assign rd_upd = go_resp & ~bad & cur_r;

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      lat_w    <= 1'b0;
      lat_r    <= 1'b0;
      lat_sel  <= 3'd0;
      lat_addr <= 32'd0;
      lat_din  <= 32'd0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      data_q   <= 32'd0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ready_q <= go_resp;
      err_q   <= go_resp & bad;
      if (accept) begin
        lat_w    <= bus.dm_w;
        lat_r    <= bus.dm_r;
        lat_sel  <= bus.select;
        lat_addr <= bus.addr;
        lat_din  <= bus.data_in;
      end
      if (rd_upd) data_q <= rd_ext;
    end
  end

  // RAM has no reset; the reset term only blocks a write from an aborted request.
  always_ff @(posedge clk) begin
    if (reset && mem_we) mem[idx] <= wr_word;
  end

  assign bus.ready    = ready_q;
  assign bus.err      = err_q;
  assign bus.data_out = data_q;

`ifdef DMEM_ACCESS_COUNT_EN
  // Counted at the end of the RESP cycle; a read and a write never succeed together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_count <= 32'd0;
      wr_count <= 32'd0;
    end else if (state == ST_RESP && !err_q) begin
      if (lat_r) rd_count <= rd_count + 32'd1;
      if (lat_w) wr_count <= wr_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH=1024, WAIT_CYCLES=2).
// Latency is counted in rising edges from the accept edge (inclusive) to the edge after which ready is seen.
// Counter checks are compiled in only when DMEM_ACCESS_COUNT_EN is defined.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if bus ();

`ifdef DMEM_ACCESS_COUNT_EN
  logic [31:0] rd_count, wr_count;
`endif

  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef DMEM_ACCESS_COUNT_EN
    ,
    .rd_count (rd_count),
    .wr_count (wr_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic bus_idle();
    bus.cs = 1'b0; bus.dm_w = 1'b0; bus.dm_r = 1'b0;
    bus.select = 3'd0; bus.addr = 32'd0; bus.data_in = 32'd0;
  endtask

  // Presents one request for a single accept edge, then waits (bounded) for ready.
  // lat = -1 if ready never came. Returns with the DUT back in IDLE.
  task automatic xfer(input logic w, input logic r, input logic [2:0] sel,
                      input logic [31:0] a, input logic [31:0] d,
                      output int lat, output logic e, output logic [31:0] q,
                      output logic rdy_after);
    @(negedge clk);
    bus.cs = 1'b1; bus.dm_w = w; bus.dm_r = r; bus.select = sel;
    bus.addr = a; bus.data_in = d;
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.dm_w = 1'b0; bus.dm_r = 1'b0;
    lat = 1;
    while (bus.ready !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (bus.ready !== 1'b1) lat = -1;
    e = bus.err;
    q = bus.data_out;
    @(posedge clk); #1;
    rdy_after = bus.ready;
  endtask

  task automatic test_reset();
    bus_idle();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.data_out !== 32'd0) begin errors++; $display("FAIL reset_data_out got=%h exp=%h", bus.data_out, 32'd0); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", bus.ready); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bus.err); end
`ifdef DMEM_ACCESS_COUNT_EN
    checks++; if (rd_count !== 32'd0) begin errors++; $display("FAIL reset_rd_count got=%0d exp=0", rd_count); end
    checks++; if (wr_count !== 32'd0) begin errors++; $display("FAIL reset_wr_count got=%0d exp=0", wr_count); end
`endif
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_word();
    int lat; logic e, ra; logic [31:0] q;
    xfer(1'b1, 1'b0, 3'd0, 32'h8, 32'hDEADBEEF, lat, e, q, ra);
    checks++; if (lat !== 3) begin errors++; $display("FAIL word_wr_latency got=%0d exp=3", lat); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL word_wr_err got=%b exp=0", e); end
    checks++; if (ra !== 1'b0) begin errors++; $display("FAIL ready_single_pulse got=%b exp=0", ra); end
    xfer(1'b0, 1'b1, 3'd0, 32'h8, 32'h0, lat, e, q, ra);
    checks++; if (lat !== 3) begin errors++; $display("FAIL word_rd_latency got=%0d exp=3", lat); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL word_rd_err got=%b exp=0", e); end
    checks++; if (q !== 32'hDEADBEEF) begin errors++; $display("FAIL word_rd_data got=%h exp=DEADBEEF", q); end
  endtask

  task automatic test_lanes();
    int lat; logic e, ra; logic [31:0] q;
    xfer(1'b1, 1'b0, 3'd3, 32'h9, 32'h0000005A, lat, e, q, ra);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL byte_wr_err got=%b exp=0", e); end
    xfer(1'b0, 1'b1, 3'd0, 32'h8, 32'h0, lat, e, q, ra);
    checks++; if (q !== 32'hDEAD5AEF) begin errors++; $display("FAIL byte_wr_merge got=%h exp=DEAD5AEF", q); end
    xfer(1'b0, 1'b1, 3'd4, 32'hB, 32'h0, lat, e, q, ra);
    checks++; if (q !== 32'hFFFFFFDE) begin errors++; $display("FAIL byte_signed_rd got=%h exp=FFFFFFDE", q); end
    xfer(1'b0, 1'b1, 3'd3, 32'hB, 32'h0, lat, e, q, ra);
    checks++; if (q !== 32'h000000DE) begin errors++; $display("FAIL byte_unsigned_rd got=%h exp=000000DE", q); end
    xfer(1'b0, 1'b1, 3'd2, 32'hA, 32'h0, lat, e, q, ra);
    checks++; if (q !== 32'hFFFFDEAD) begin errors++; $display("FAIL half_signed_rd got=%h exp=FFFFDEAD", q); end
    xfer(1'b0, 1'b1, 3'd1, 32'h9, 32'h0, lat, e, q, ra);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL half_misaligned_err got=%b exp=1", e); end
    checks++; if (q !== 32'hFFFFDEAD) begin errors++; $display("FAIL half_misaligned_hold got=%h exp=FFFFDEAD", q); end
    xfer(1'b0, 1'b1, 3'd1, 32'h8, 32'h0, lat, e, q, ra);
    checks++; if (q !== 32'h00005AEF) begin errors++; $display("FAIL half_unsigned_rd got=%h exp=00005AEF", q); end
    xfer(1'b1, 1'b0, 3'd1, 32'hA, 32'hFFFF1234, lat, e, q, ra);
    xfer(1'b0, 1'b1, 3'd0, 32'h8, 32'h0, lat, e, q, ra);
    checks++; if (q !== 32'h12345AEF) begin errors++; $display("FAIL half_wr_upper got=%h exp=12345AEF", q); end
  endtask

  task automatic test_errors();
    int lat; logic e, ra; logic [31:0] q;
    xfer(1'b1, 1'b0, 3'd0, 32'hFFC, 32'h11223344, lat, e, q, ra);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL top_word_wr_err got=%b exp=0", e); end
    xfer(1'b1, 1'b0, 3'd0, 32'h1000, 32'hAAAAAAAA, lat, e, q, ra);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL out_of_range_wr_err got=%b exp=1", e); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL err_latency got=%0d exp=3", lat); end
    xfer(1'b0, 1'b1, 3'd0, 32'hFFC, 32'h0, lat, e, q, ra);
    checks++; if (q !== 32'h11223344) begin errors++; $display("FAIL top_word_rd got=%h exp=11223344", q); end
    xfer(1'b0, 1'b1, 3'd0, 32'hFFFFFFFC, 32'h0, lat, e, q, ra);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL high_addr_err got=%b exp=1", e); end
    checks++; if (q !== 32'h11223344) begin errors++; $display("FAIL high_addr_hold got=%h exp=11223344", q); end
    xfer(1'b0, 1'b1, 3'd0, 32'h6, 32'h0, lat, e, q, ra);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL word_misaligned_err got=%b exp=1", e); end
    xfer(1'b1, 1'b1, 3'd0, 32'h8, 32'h0, lat, e, q, ra);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL rd_and_wr_err got=%b exp=1", e); end
    xfer(1'b0, 1'b1, 3'd5, 32'h8, 32'h0, lat, e, q, ra);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL bad_select_err got=%b exp=1", e); end
    xfer(1'b1, 1'b0, 3'd0, 32'h9, 32'hFFFFFFFF, lat, e, q, ra);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL word_misaligned_wr_err got=%b exp=1", e); end
    xfer(1'b0, 1'b1, 3'd0, 32'h8, 32'h0, lat, e, q, ra);
    checks++; if (q !== 32'h12345AEF) begin errors++; $display("FAIL rejected_wr_no_effect got=%h exp=12345AEF", q); end
  endtask

  task automatic test_reset_mid();
    int lat; logic e, ra; logic [31:0] q;
    logic seen;
    xfer(1'b1, 1'b0, 3'd0, 32'h10, 32'hCAFEF00D, lat, e, q, ra);
    @(negedge clk);
    bus.cs = 1'b1; bus.dm_w = 1'b1; bus.dm_r = 1'b0; bus.select = 3'd0;
    bus.addr = 32'h10; bus.data_in = 32'h12345678;
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (bus.data_out !== 32'd0) begin errors++; $display("FAIL midreset_data_out got=%h exp=0", bus.data_out); end
    checks++; if (bus.ready !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL midreset_flags got=%b%b exp=00", bus.ready, bus.err); end
    seen = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (bus.ready === 1'b1) seen = 1'b1; end
    @(negedge clk);
    reset = 1'b1;
    repeat (6) begin @(posedge clk); #1; if (bus.ready === 1'b1) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midreset_no_ready got=%b exp=0", seen); end
    xfer(1'b0, 1'b1, 3'd0, 32'h10, 32'h0, lat, e, q, ra);
    checks++; if (q !== 32'hCAFEF00D) begin errors++; $display("FAIL midreset_ram_kept got=%h exp=CAFEF00D", q); end
  endtask

  task automatic test_back_to_back();
    int pulse_at[$];
`ifdef DMEM_ACCESS_COUNT_EN
    logic [31:0] rd_at[$];
    logic [31:0] wr0;
    wr0 = wr_count;
`endif
    @(negedge clk);
    bus.cs = 1'b1; bus.dm_w = 1'b0; bus.dm_r = 1'b1; bus.select = 3'd0;
    bus.addr = 32'h8; bus.data_in = 32'h0;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); #1;
      if (bus.ready === 1'b1) begin
        pulse_at.push_back(k);
`ifdef DMEM_ACCESS_COUNT_EN
        rd_at.push_back(rd_count);
`endif
      end
    end
    bus_idle();
    repeat (6) @(posedge clk);
    #1;
    checks++; if (pulse_at.size() !== 6) begin errors++; $display("FAIL b2b_pulse_count got=%0d exp=6", pulse_at.size()); end
    if (pulse_at.size() > 0) begin
      checks++; if (pulse_at[0] !== 3) begin errors++; $display("FAIL b2b_first_pulse got=%0d exp=3", pulse_at[0]); end
    end
    for (int i = 1; i < pulse_at.size(); i++) begin
      checks++;
      if (pulse_at[i] - pulse_at[i-1] !== 4) begin
        errors++; $display("FAIL b2b_period idx=%0d got=%0d exp=4", i, pulse_at[i] - pulse_at[i-1]);
      end
    end
`ifdef DMEM_ACCESS_COUNT_EN
    for (int i = 1; i < rd_at.size(); i++) begin
      checks++;
      if (rd_at[i] - rd_at[i-1] !== 32'd1) begin
        errors++; $display("FAIL b2b_rd_count_step idx=%0d got=%0d exp=1", i, rd_at[i] - rd_at[i-1]);
      end
    end
    checks++; if (wr_count !== wr0) begin errors++; $display("FAIL b2b_wr_count got=%0d exp=%0d", wr_count, wr0); end
`endif
  endtask

  initial begin
    test_reset();
    test_word();
    test_lanes();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
